// File: rtl/gate_sweep_pkg.sv
// Shared types and the reference truth table for the two-input gate sweep.
// Bit order of every 7-bit gate vector follows the GI_* indices below.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int GATE_W  = 7;
    localparam int GI_NOT  = 0;
    localparam int GI_AND  = 1;
    localparam int GI_OR   = 2;
    localparam int GI_NAND = 3;
    localparam int GI_NOR  = 4;
    localparam int GI_XOR  = 5;
    localparam int GI_XNOR = 6;

    // The not gate only looks at operand a.
    function automatic logic [GATE_W-1:0] gate_expect(input logic a, input logic b);
        logic [GATE_W-1:0] v;
        v          = '0;
        v[GI_NOT]  = ~a;
        v[GI_AND]  = a & b;
        v[GI_OR]   = a | b;
        v[GI_NAND] = ~(a & b);
        v[GI_NOR]  = ~(a | b);
        v[GI_XOR]  = a ^ b;
        v[GI_XNOR] = ~(a ^ b);
        return v;
    endfunction

endpackage

// File: rtl/gate_expect_rom.sv
// Combinational lookup: 2-bit operand index {a,b} to the expected gate vector.
module gate_expect_rom
    import gate_sweep_pkg::*;
(
    input  logic [1:0]        idx,
    output logic [GATE_W-1:0] exp_vec
);

    assign exp_vec = gate_expect(idx[1], idx[0]);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sequencer that sweeps the gate block through all four operand pairs,
// checks each result against the truth table and reports a sticky error mask.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] y_in,
    output logic              a_o,
    output logic              b_o,
    output logic [1:0]        vec_idx,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [GATE_W-1:0] err_mask
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [1:0]        vec_nx;
    logic [GATE_W-1:0] err_nx;
    logic [GATE_W-1:0] exp_vec;
    logic              busy_nx, done_nx, pass_nx;

    gate_expect_rom u_rom (
        .idx     (vec_idx),
        .exp_vec (exp_vec)
    );

    // Operands are plain flop bits of the vector index, so they move with it.
    assign a_o = vec_idx[1];
    assign b_o = vec_idx[0];

    always_comb begin
        // NOTE: every next-value gets a default before the case so no path leaves it unassigned (no latches).
        state_nx = state;
        cnt_nx   = cnt;
        vec_nx   = vec_idx;
        err_nx   = err_mask;
        busy_nx  = busy;
        pass_nx  = pass;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = DRIVE;
                    vec_nx   = 2'd0;
                    err_nx   = '0;
                    pass_nx  = 1'b0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            DRIVE: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == SETTLE_LAST) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                // y_in is only trusted here, after the operands have settled.
                err_nx = err_mask | (y_in ^ exp_vec);
                if (vec_idx == 2'd3) begin
                    state_nx = DONE;
                end else begin
                    vec_nx   = vec_idx + 2'd1;
                    cnt_nx   = '0;
                    state_nx = DRIVE;
                end
            end
            DONE: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b1;
                pass_nx  = (err_mask == '0);
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous, so rst is just the highest-priority branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vec_idx  <= 2'd0;
            err_mask <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            vec_idx  <= vec_nx;
            err_mask <= err_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pass     <= pass_nx;
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized self-checking bench: two checkers (settle 2 and settle 1) each
// wired to a behavioural gate block whose output the bench can corrupt.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start2, start1;
    logic [6:0] y_in2, y_in1;
    logic       a2, b2, busy2, done2, pass2;
    logic       a1, b1, busy1, done1, pass1;
    logic [1:0] vec2, vec1;
    logic [6:0] err2, err1;

    logic       noise_now;
    logic [6:0] rnd_now, cor_now, keep_m, set_m;
    logic       sel;
    logic [6:0] cor_tab [4];
    logic       noise_en;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input bit ok, input string msg);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s", msg);
        end
    endtask

    // Truth table written straight from the gate definitions.
    function automatic logic [6:0] ref_gates(input logic a, input logic b);
        logic [6:0] r;
        r[0] = !a;
        r[1] = a && b;
        r[2] = a || b;
        r[3] = !(a && b);
        r[4] = !(a || b);
        r[5] = a != b;
        r[6] = a == b;
        return r;
    endfunction

    assign y_in2 = noise_now ? rnd_now : (((ref_gates(a2, b2) ^ cor_now) & keep_m) | set_m);
    assign y_in1 = noise_now ? rnd_now : (((ref_gates(a1, b1) ^ cor_now) & keep_m) | set_m);

    gate_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .y_in(y_in2),
        .a_o(a2), .b_o(b2), .vec_idx(vec2), .busy(busy2),
        .done(done2), .pass(pass2), .err_mask(err2)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y_in1),
        .a_o(a1), .b_o(b1), .vec_idx(vec1), .busy(busy1),
        .done(done1), .pass(pass1), .err_mask(err1)
    );

    logic [13:0] obs;
    assign obs = sel ? {vec1, a1, b1, busy1, done1, pass1, err1}
                     : {vec2, a2, b2, busy2, done2, pass2, err2};

    // Drives one sweep on the selected checker and checks every cycle from the
    // accepting edge through the done pulse, then the idle hold afterwards.
    task automatic run_sweep(input int s, input bit accepted, input bit hold,
                             output logic [6:0] fin_err, output logic fin_pass);
        int          lat, v, pv;
        bit          samp;
        logic [1:0]  ev;
        logic [6:0]  good;
        logic [13:0] exp_o;
        lat = 1 + 4 * (s + 1);
        sel = (s == 1);
        if (!accepted) begin
            if (sel) start1 = 1'b1; else start2 = 1'b1;
            @(posedge clk); #1;
        end
        if (!hold) begin
            start1 = 1'b0;
            start2 = 1'b0;
        end
        fin_err  = '0;
        fin_pass = 1'b0;
        for (int e = 0; e <= lat; e++) begin
            v    = e / (s + 1);
            samp = ((e % (s + 1)) == s) && (e < 4 * (s + 1));
            if (v > 3) v = 3;
            ev        = v[1:0];
            cor_now   = cor_tab[v];
            noise_now = noise_en && !samp;
            rnd_now   = 7'($urandom);
            if (e > 0 && (e % (s + 1)) == 0 && e <= 4 * (s + 1)) begin
                pv      = e / (s + 1) - 1;
                good    = ref_gates(pv[1], pv[0]);
                fin_err = fin_err | ((((good ^ cor_tab[pv]) & keep_m) | set_m) ^ good);
            end
            if (e == lat) fin_pass = (fin_err == 7'h00);
            exp_o = {ev, ev[1], ev[0], 1'b1, (e == lat), fin_pass, fin_err};
            @(negedge clk);
            check(obs === exp_o,
                  $sformatf("sweep s=%0d cyc=%0d {vec,a,b,busy,done,pass,err} got=%h exp=%h",
                            s, e, obs, exp_o));
            @(posedge clk); #1;
        end
        noise_now = 1'b0;
        if (!hold) begin
            for (int k = 0; k < 3; k++) begin
                exp_o = {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, fin_pass, fin_err};
                @(negedge clk);
                check(obs === exp_o,
                      $sformatf("idle_hold s=%0d k=%0d got=%h exp=%h", s, k, obs, exp_o));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic set_clean();
        for (int i = 0; i < 4; i++) cor_tab[i] = '0;
        keep_m   = 7'h7F;
        set_m    = 7'h00;
        noise_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b1; start2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check({vec2, a2, b2, busy2, done2, pass2, err2, vec1, a1, b1, busy1, done1, pass1, err1} === 28'h0,
              $sformatf("reset_with_start got2=%h got1=%h exp=0",
                        {vec2, a2, b2, busy2, done2, pass2, err2}, {vec1, a1, b1, busy1, done1, pass1, err1}));
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({busy2, done2, busy1, done1} === 4'h0,
              $sformatf("reset_idle busy/done got=%b exp=0000", {busy2, done2, busy1, done1}));
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        logic [6:0] fe; logic fp;
        set_clean();
        run_sweep(2, 1'b0, 1'b0, fe, fp);
        check({pass2, err2} === 8'h80,
              $sformatf("clean_result got pass=%b err=%h exp pass=1 err=00", pass2, err2));
    endtask

    task automatic test_xor_stuck();
        logic [6:0] fe; logic fp;
        set_clean();
        keep_m = 7'h5F;
        run_sweep(2, 1'b0, 1'b0, fe, fp);
        check({pass2, err2} === {1'b0, 7'h20},
              $sformatf("xor_stuck got pass=%b err=%h exp pass=0 err=20", pass2, err2));
    endtask

    task automatic test_all_ones();
        logic [6:0] fe; logic fp;
        set_clean();
        set_m = 7'h7F;
        run_sweep(2, 1'b0, 1'b0, fe, fp);
        check(pass2 === 1'b0, $sformatf("all_ones_pass got=%b exp=0", pass2));
    endtask

    task automatic test_back_to_back();
        logic [6:0] fe; logic fp;
        set_clean();
        cor_tab[2] = 7'h08;
        run_sweep(2, 1'b0, 1'b1, fe, fp);
        cor_tab[2] = 7'h00;
        run_sweep(2, 1'b1, 1'b0, fe, fp);
    endtask

    task automatic test_reset_mid();
        logic [6:0] fe; logic fp;
        set_clean();
        cor_tab[0] = 7'h01;
        cor_tab[1] = 7'h40;
        sel = 1'b0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(obs === 14'h0, $sformatf("reset_mid_values got=%h exp=0000", obs));
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check({busy2, done2, err2} === 9'h0,
                  $sformatf("reset_mid_quiet k=%0d busy/done/err got=%h exp=000", k, {busy2, done2, err2}));
        end
        @(posedge clk); #1;
        set_clean();
        run_sweep(2, 1'b0, 1'b0, fe, fp);
        check(pass2 === 1'b1, $sformatf("reset_mid_resweep pass got=%b exp=1", pass2));
    endtask

    task automatic test_settle1_noise();
        logic [6:0] fe; logic fp;
        set_clean();
        noise_en = 1'b1;
        run_sweep(1, 1'b0, 1'b0, fe, fp);
        check({pass1, err1} === 8'h80,
              $sformatf("settle1_noise got pass=%b err=%h exp pass=1 err=00", pass1, err1));
    endtask

    task automatic test_random();
        logic [6:0] fe; logic fp;
        int s;
        for (int it = 0; it < 10; it++) begin
            set_clean();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 2) == 0) cor_tab[i] = 7'($urandom);
            if ($urandom_range(0, 3) == 0) keep_m = 7'($urandom);
            noise_en = 1'($urandom_range(0, 1));
            s = $urandom_range(1, 2);
            run_sweep(s, 1'b0, 1'b0, fe, fp);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        noise_now = 1'b0; rnd_now = '0; cor_now = '0; sel = 1'b0;
        set_clean();
        test_reset();
        test_clean();
        test_xor_stuck();
        test_all_ones();
        test_back_to_back();
        test_reset_mid();
        test_settle1_noise();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
